// File: rtl/dp_pipe.sv
// dp_pipe: parametrised two-stage register-file/ALU datapath.
// Stage 1 reads operands and issues them under a valid/ready handshake.
// Stage 2 executes and writes back.
// The EX result is bypassed to the issuing op so that dependent ops never stall.
// Optional feature macro: DP_MUL_EN compiles in an iterative shift-add
// multiplier (XLEN cycles per MUL). Without it, MUL behaves as an unknown
// opcode and yields 0.

package dp_pipe_pkg;
    localparam logic [6:0] OP_ADD  = 7'h00;
    localparam logic [6:0] OP_SUB  = 7'h01;
    localparam logic [6:0] OP_AND  = 7'h02;
    localparam logic [6:0] OP_OR   = 7'h03;
    localparam logic [6:0] OP_XOR  = 7'h04;
    localparam logic [6:0] OP_SLL  = 7'h05;
    localparam logic [6:0] OP_SRL  = 7'h06;
    localparam logic [6:0] OP_SRA  = 7'h07;
    localparam logic [6:0] OP_SLT  = 7'h08;
    localparam logic [6:0] OP_SLTU = 7'h09;
    localparam logic [6:0] OP_MUL  = 7'h0A;
endpackage

module dp_pipe
    import dp_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      op,
    input  logic [AW-1:0]   addr_a,
    input  logic [AW-1:0]   addr_b,
    input  logic [AW-1:0]   addr_d,
    input  logic [XLEN-1:0] immed,
    input  logic            y_sel,
    input  logic            write,
    output logic [XLEN-1:0] a_out,
    output logic [XLEN-1:0] b_out,
    output logic [XLEN-1:0] w_out,
    output logic [AW-1:0]   w_addr,
    output logic            out_valid,
    output logic            busy
);

    localparam int SHW  = $clog2(XLEN);
    localparam int NREG = 2 ** AW;

`ifdef DP_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_EX, S_MUL} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_EX} state_t;
`endif

    state_t          state;

    logic [XLEN-1:0] rf [NREG];

    logic [6:0]      ex_op;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [AW-1:0]   ex_addr_d;
    logic            ex_write;

    logic            accept;
    logic            ex_done;
    logic            wb_en;
    logic [XLEN-1:0] alu_y;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] rd_a;
    logic [XLEN-1:0] rd_b;
    logic [XLEN-1:0] opnd_b;
    logic [SHW-1:0]  shamt;

`ifdef DP_MUL_EN
    logic [SHW-1:0]  mul_cnt;
    logic [XLEN-1:0] mul_acc;
    logic [XLEN-1:0] mul_mcand;
    logic [XLEN-1:0] mul_mplier;
    logic [XLEN-1:0] mul_acc_nxt;

    // One shift-add step; the last step's sum is the completed product.
    assign mul_acc_nxt = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
    assign ex_done     = (state == S_EX) || ((state == S_MUL) && (mul_cnt == '0));
    assign ex_result   = (state == S_MUL) ? mul_acc_nxt : alu_y;
    assign in_ready    = reset && (state != S_MUL);
    assign busy        = (state == S_MUL);
`else
    assign ex_done     = (state == S_EX);
    assign ex_result   = alu_y;
    assign in_ready    = reset;
    assign busy        = 1'b0;
`endif

    assign accept = in_valid && in_ready;

    // Writes to r0 are dropped, so r0 is also never a bypass source.
    assign wb_en  = ex_done && ex_write && (ex_addr_d != '0);

    assign rd_a   = (wb_en && (addr_a == ex_addr_d)) ? ex_result : rf[addr_a];
    assign rd_b   = (wb_en && (addr_b == ex_addr_d)) ? ex_result : rf[addr_b];
    assign opnd_b = y_sel ? immed : rd_b;
    assign shamt  = ex_b[SHW-1:0];

    // Single-cycle ALU on the operands captured at issue; unknown opcodes give 0.
    always_comb begin
        alu_y = '0;
        case (ex_op)
            OP_ADD:  alu_y = ex_a + ex_b;
            OP_SUB:  alu_y = ex_a - ex_b;
            OP_AND:  alu_y = ex_a & ex_b;
            OP_OR:   alu_y = ex_a | ex_b;
            OP_XOR:  alu_y = ex_a ^ ex_b;
            OP_SLL:  alu_y = ex_a << shamt;
            OP_SRL:  alu_y = ex_a >> shamt;
            OP_SRA:  alu_y = XLEN'($signed(ex_a) >>> shamt);
            OP_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
            OP_SLTU: alu_y = {{(XLEN-1){1'b0}}, (ex_a < ex_b)};
            default: alu_y = '0;
        endcase
    end

    // Issue capture, FSM sequencing and (optionally) multiplier iteration.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            ex_op     <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_addr_d <= '0;
            ex_write  <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
`ifdef DP_MUL_EN
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
`endif
        end else begin
            if (accept) begin
                a_out     <= rd_a;
                b_out     <= rd_b;
                ex_a      <= rd_a;
                ex_b      <= opnd_b;
                ex_op     <= op;
                ex_addr_d <= addr_d;
                ex_write  <= write;
            end
`ifdef DP_MUL_EN
            if (state == S_MUL) begin
                mul_acc    <= mul_acc_nxt;
                mul_mcand  <= mul_mcand << 1;
                mul_mplier <= mul_mplier >> 1;
                if (mul_cnt == '0) begin
                    state <= S_IDLE;
                end else begin
                    mul_cnt <= mul_cnt - 1'b1;
                end
            end else if (accept) begin
                if (op == OP_MUL) begin
                    state      <= S_MUL;
                    mul_cnt    <= SHW'(XLEN - 1);
                    mul_acc    <= '0;
                    mul_mcand  <= rd_a;
                    mul_mplier <= opnd_b;
                end else begin
                    state <= S_EX;
                end
            end else begin
                state <= S_IDLE;
            end
`else
            if (accept) begin
                state <= S_EX;
            end else begin
                state <= S_IDLE;
            end
`endif
        end
    end

    // Register file: cleared by reset, written once per completed op with write set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en) begin
            rf[ex_addr_d] <= ex_result;
        end
    end

    // Completion outputs: result and destination hold between completions.
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_out     <= '0;
            w_addr    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= ex_done;
            if (ex_done) begin
                w_out  <= ex_result;
                w_addr <= ex_addr_d;
            end
        end
    end

endmodule

// File: tb/tb_dp_pipe.sv
// tb_dp_pipe: directed-vector bench for dp_pipe (XLEN=32, AW=5).
// MUL expectations follow whether DP_MUL_EN is defined for the build.

module tb_dp_pipe;
    import dp_pipe_pkg::*;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      op;
    logic [AW-1:0]   addr_a;
    logic [AW-1:0]   addr_b;
    logic [AW-1:0]   addr_d;
    logic [XLEN-1:0] immed;
    logic            y_sel;
    logic            write;
    logic [XLEN-1:0] a_out;
    logic [XLEN-1:0] b_out;
    logic [XLEN-1:0] w_out;
    logic [AW-1:0]   w_addr;
    logic            out_valid;
    logic            busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] imm;
        logic        ys;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [18];

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    dp_pipe #(.XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .addr_d    (addr_d),
        .immed     (immed),
        .y_sel     (y_sel),
        .write     (write),
        .a_out     (a_out),
        .b_out     (b_out),
        .w_out     (w_out),
        .w_addr    (w_addr),
        .out_valid (out_valid),
        .busy      (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] o, input logic [4:0] a, input logic [4:0] b,
                                 input logic [4:0] d, input logic [31:0] imm,
                                 input logic ys, input logic wr);
        in_valid = 1'b1;
        op       = o;
        addr_a   = a;
        addr_b   = b;
        addr_d   = d;
        immed    = imm;
        y_sel    = ys;
        write    = wr;
        tick();
    endtask

    task automatic idleCycle;
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        int    busy_cycles;
        logic  saw_pulse;

        // r4=20, r5=14, r6=40, r7=FFFFFFFF, r8=FFFFFF00 when this table runs
        vecs[0]  = '{OP_AND,  5'd6, 5'd0, 32'h0000000F, 1'b1, 32'h00000008};
        vecs[1]  = '{OP_OR,   5'd6, 5'd0, 32'h00000003, 1'b1, 32'h0000002B};
        vecs[2]  = '{OP_XOR,  5'd7, 5'd0, 32'h000000FF, 1'b1, 32'hFFFFFF00};
        vecs[3]  = '{OP_SLL,  5'd5, 5'd0, 32'h00000004, 1'b1, 32'h000000E0};
        vecs[4]  = '{OP_SLL,  5'd4, 5'd0, 32'h00000021, 1'b1, 32'h00000028};
        vecs[5]  = '{OP_SRL,  5'd7, 5'd0, 32'h0000001C, 1'b1, 32'h0000000F};
        vecs[6]  = '{OP_SRL,  5'd7, 5'd0, 32'h0000001F, 1'b1, 32'h00000001};
        vecs[7]  = '{OP_SRA,  5'd8, 5'd0, 32'h00000004, 1'b1, 32'hFFFFFFF0};
        vecs[8]  = '{OP_SRL,  5'd8, 5'd0, 32'h00000004, 1'b1, 32'h0FFFFFF0};
        vecs[9]  = '{OP_SLT,  5'd7, 5'd0, 32'h00000001, 1'b1, 32'h00000001};
        vecs[10] = '{OP_SLTU, 5'd7, 5'd0, 32'h00000001, 1'b1, 32'h00000000};
        vecs[11] = '{OP_SLT,  5'd4, 5'd0, 32'hFFFFFFFF, 1'b1, 32'h00000000};
        vecs[12] = '{OP_SLTU, 5'd4, 5'd0, 32'hFFFFFFFF, 1'b1, 32'h00000001};
        vecs[13] = '{OP_SUB,  5'd4, 5'd0, 32'h00000020, 1'b1, 32'hFFFFFFF4};
        vecs[14] = '{OP_SUB,  5'd6, 5'd4, 32'h00000000, 1'b0, 32'h00000014};
        vecs[15] = '{7'h7F,   5'd6, 5'd0, 32'h00000001, 1'b1, 32'h00000000};
        vecs[16] = '{OP_ADD,  5'd5, 5'd0, 32'h00000000, 1'b1, 32'h0000000E};
        vecs[17] = '{OP_ADD,  5'd7, 5'd0, 32'h00000002, 1'b1, 32'h00000001};

        // Reset held with a valid write request pending
        reset    = 1'b0;
        in_valid = 1'b1;
        op       = OP_ADD;
        addr_a   = 5'd0;
        addr_b   = 5'd0;
        addr_d   = 5'd1;
        immed    = 32'd5;
        y_sel    = 1'b1;
        write    = 1'b1;
        #1;
        checkOutput("rst_in_ready_pre", 32'(in_ready), 32'd0);
        tick();
        tick();
        checkOutput("rst_a_out",     a_out,            32'd0);
        checkOutput("rst_b_out",     b_out,            32'd0);
        checkOutput("rst_w_out",     w_out,            32'd0);
        checkOutput("rst_w_addr",    32'(w_addr),      32'd0);
        checkOutput("rst_out_valid", 32'(out_valid),   32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),    32'd0);
        checkOutput("rst_busy",      32'(busy),        32'd0);

        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("rel_no_valid", 32'(out_valid), 32'd0);
        applyStimulus(OP_ADD, 5'd1, 5'd0, 5'd8, 32'd0, 1'b1, 1'b0);
        checkOutput("rel_r1_zero", a_out, 32'd0);
        idleCycle();

        // Basic immediate ADD into r1, then read r1 back from the file
        applyStimulus(OP_ADD, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 1'b1);
        idleCycle();
        checkOutput("add_w_out",     w_out,           32'd5);
        checkOutput("add_w_addr",    32'(w_addr),     32'd1);
        checkOutput("add_out_valid", 32'(out_valid),  32'd1);
        idleCycle();
        checkOutput("add_pulse_end", 32'(out_valid),  32'd0);
        checkOutput("add_w_hold",    w_out,           32'd5);
        applyStimulus(OP_ADD, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("add_r1_read", a_out, 32'd5);
        idleCycle();

        // Back-to-back dependent ops resolved by bypass on A and B
        applyStimulus(OP_ADD, 5'd0, 5'd0, 5'd4, 32'd11, 1'b1, 1'b1);
        applyStimulus(OP_ADD, 5'd4, 5'd0, 5'd5, 32'd3, 1'b1, 1'b1);
        checkOutput("byp_a_out",     a_out,           32'd11);
        checkOutput("byp_w_r4",      w_out,           32'd11);
        checkOutput("byp_in_ready",  32'(in_ready),   32'd1);
        applyStimulus(OP_ADD, 5'd0, 5'd0, 5'd4, 32'd20, 1'b1, 1'b1);
        checkOutput("byp_w_r5",      w_out,           32'd14);
        checkOutput("byp_b2b_valid", 32'(out_valid),  32'd1);
        applyStimulus(OP_ADD, 5'd4, 5'd4, 5'd6, 32'd0, 1'b0, 1'b1);
        checkOutput("byp_ab_a_out",  a_out,           32'd20);
        checkOutput("byp_ab_b_out",  b_out,           32'd20);
        applyStimulus(OP_SUB, 5'd0, 5'd0, 5'd7, 32'd1, 1'b1, 1'b1);
        checkOutput("byp_w_r6",      w_out,           32'd40);
        checkOutput("byp_w_addr6",   32'(w_addr),     32'd6);
        idleCycle();
        checkOutput("sub_wrap",      w_out,           32'hFFFFFFFF);
        checkOutput("sub_w_addr",    32'(w_addr),     32'd7);
        idleCycle();
        checkOutput("sub_pulse_end", 32'(out_valid),  32'd0);

        // r0 destination: result visible, never written and never bypassed
        applyStimulus(OP_ADD, 5'd0, 5'd0, 5'd0, 32'd7, 1'b1, 1'b1);
        applyStimulus(OP_ADD, 5'd0, 5'd0, 5'd8, 32'd0, 1'b1, 1'b0);
        checkOutput("r0_w_out",  w_out,       32'd7);
        checkOutput("r0_w_addr", 32'(w_addr), 32'd0);
        checkOutput("r0_a_out",  a_out,       32'd0);
        idleCycle();

        // ALU opcode table
        applyStimulus(OP_SUB, 5'd0, 5'd0, 5'd8, 32'h100, 1'b1, 1'b1);
        idleCycle();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 5'd9, vecs[i].imm, vecs[i].ys, 1'b0);
            idleCycle();
            checkOutput($sformatf("alu_%0d", i), w_out, vecs[i].exp);
        end

        // MUL r3 = r1 * r2 with a second op held behind it
        applyStimulus(OP_ADD, 5'd0, 5'd0, 5'd2, 32'd8, 1'b1, 1'b1);
        idleCycle();
        applyStimulus(OP_MUL, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1);
`ifdef DP_MUL_EN
        checkOutput("mul_busy",     32'(busy),     32'd1);
        checkOutput("mul_in_ready", 32'(in_ready), 32'd0);
        in_valid    = 1'b1;
        op          = OP_ADD;
        addr_a      = 5'd3;
        addr_b      = 5'd0;
        addr_d      = 5'd10;
        immed       = 32'd0;
        y_sel       = 1'b1;
        write       = 1'b0;
        busy_cycles = 0;
        saw_pulse   = 1'b0;
        while (busy && (busy_cycles < 100)) begin
            busy_cycles++;
            if (out_valid || in_ready) saw_pulse = 1'b1;
            tick();
        end
        checkOutput("mul_busy_cycles", 32'(busy_cycles), 32'd32);
        checkOutput("mul_quiet",       32'(saw_pulse),   32'd0);
        checkOutput("mul_w_out",       w_out,            32'd40);
        checkOutput("mul_w_addr",      32'(w_addr),      32'd3);
        checkOutput("mul_out_valid",   32'(out_valid),   32'd1);
        checkOutput("mul_ready_back",  32'(in_ready),    32'd1);
        checkOutput("mul_held_a_out",  a_out,            32'd5);
        tick();
        checkOutput("held_a_out",      a_out,            32'd40);
        checkOutput("mul_single_pulse", 32'(out_valid),  32'd0);
        idleCycle();
        checkOutput("held_w_out",      w_out,            32'd40);
        checkOutput("held_w_addr",     32'(w_addr),      32'd10);
`else
        checkOutput("nomul_busy",     32'(busy),     32'd0);
        checkOutput("nomul_in_ready", 32'(in_ready), 32'd1);
        idleCycle();
        checkOutput("nomul_w_out",     w_out,          32'd0);
        checkOutput("nomul_w_addr",    32'(w_addr),    32'd3);
        checkOutput("nomul_out_valid", 32'(out_valid), 32'd1);
        checkOutput("nomul_busy_after", 32'(busy),     32'd0);
`endif

        // Reset while an op is in flight aborts it
        applyStimulus(OP_MUL, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1);
        in_valid = 1'b0;
`ifdef DP_MUL_EN
        repeat (9) tick();
        checkOutput("abort_busy_pre", 32'(busy), 32'd1);
`endif
        reset = 1'b0;
        tick();
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_busy",      32'(busy),      32'd0);
        checkOutput("abort_in_ready",  32'(in_ready),  32'd0);
        checkOutput("abort_w_out",     w_out,          32'd0);
        reset = 1'b1;
        #1;
        checkOutput("abort_ready_rel", 32'(in_ready), 32'd1);
        saw_pulse = 1'b0;
        repeat (40) begin
            if (out_valid) saw_pulse = 1'b1;
            tick();
        end
        checkOutput("abort_no_pulse", 32'(saw_pulse), 32'd0);
        applyStimulus(OP_ADD, 5'd3, 5'd1, 5'd12, 32'd0, 1'b0, 1'b0);
        checkOutput("abort_r3_zero", a_out, 32'd0);
        checkOutput("abort_r1_zero", b_out, 32'd0);
        idleCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
